// File: rtl/capture_sequencer.sv
// Sequences one capture of the image datapath (reset, wait for end flag, latch, classify).
// Macro CAPTURE_TIMEOUT_EN enables the WAIT-state watchdog and the timeout status.
module capture_sequencer #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter int unsigned MIN_PIXELS     = 64,
  parameter int unsigned CW             = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        proc_end,
  input  logic [19:0] red_cnt,
  input  logic [19:0] green_cnt,
  input  logic [19:0] blue_cnt,
  input  logic [11:0] w_mayor,
  input  logic [11:0] w_menor,
  input  logic [11:0] w_igual,
  output logic        proc_reset,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [1:0]  color,
  output logic [1:0]  shape,
  output logic [19:0] max_cnt
);
  localparam int unsigned PW = 20;
  localparam int unsigned WW = 12;
  localparam int unsigned SW = 14;
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_WAIT, S_SETTLE, S_LATCH, S_CLASSIFY, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           end_m_q, end_m_d, end_s_q, end_s_d;
  logic           proc_reset_q, proc_reset_d;
  logic           busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic [1:0]     color_q, color_d, shape_q, shape_d;
  logic [PW-1:0]  max_cnt_q, max_cnt_d;
  logic [PW-1:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [WW-1:0]  mayor_q, mayor_d, menor_q, menor_d, igual_q, igual_d;

  logic [1:0]     win_col_c, shape_c;
  logic [PW-1:0]  win_cnt_c;
  logic [SW-1:0]  sum_mm_c, sum_all_c, dbl_menor_c;

`ifdef CAPTURE_TIMEOUT_EN
  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT_CYCLES - 1);
`else
  logic [CW-1:0] unused_wdog_c;
  assign unused_wdog_c = CW'(TIMEOUT_CYCLES);
`endif

  // Classification over the latched snapshot; ties keep the earlier colour.
  always_comb begin
    win_col_c = 2'd1;
    win_cnt_c = red_q;
    if (green_q > win_cnt_c) begin
      win_col_c = 2'd2;
      win_cnt_c = green_q;
    end
    if (blue_q > win_cnt_c) begin
      win_col_c = 2'd3;
      win_cnt_c = blue_q;
    end
    if (win_cnt_c < PW'(MIN_PIXELS)) win_col_c = 2'd0;

    sum_mm_c    = SW'(mayor_q) + SW'(menor_q);
    sum_all_c   = sum_mm_c + SW'(igual_q);
    dbl_menor_c = SW'(menor_q) << 1;
    if (sum_all_c == '0)                 shape_c = 2'd0;
    else if (SW'(igual_q) > sum_mm_c)    shape_c = 2'd1;
    else if (SW'(mayor_q) > dbl_menor_c) shape_c = 2'd2;
    else                                 shape_c = 2'd3;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    end_m_d   = proc_end;
    end_s_d   = end_m_q;
    busy_d    = busy_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    color_d   = color_q;
    shape_d   = shape_q;
    max_cnt_d = max_cnt_q;
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;
    mayor_d   = mayor_q;
    menor_d   = menor_q;
    igual_d   = igual_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d    = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = S_RST;
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
`ifdef CAPTURE_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
        if (end_s_q) begin
          state_d = S_SETTLE;
        end else if (cnt_q == WDOG_LAST) begin
          cnt_d     = '0;
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          color_d   = 2'd0;
          shape_d   = 2'd0;
          max_cnt_d = '0;
        end
`else
        if (end_s_q) state_d = S_SETTLE;
`endif
      end
      S_SETTLE: state_d = S_LATCH;
      S_LATCH: begin
        red_d   = red_cnt;
        green_d = green_cnt;
        blue_d  = blue_cnt;
        mayor_d = w_mayor;
        menor_d = w_menor;
        igual_d = w_igual;
        state_d = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        color_d   = win_col_c;
        shape_d   = shape_c;
        max_cnt_d = win_cnt_c;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Datapath runs only while the shot is live; counts must not be cleared before latching.
    proc_reset_d = !(state_d inside {S_WAIT, S_SETTLE, S_LATCH, S_CLASSIFY});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      end_m_q      <= 1'b0;
      end_s_q      <= 1'b0;
      proc_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      color_q      <= 2'd0;
      shape_q      <= 2'd0;
      max_cnt_q    <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      mayor_q      <= '0;
      menor_q      <= '0;
      igual_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      end_m_q      <= end_m_d;
      end_s_q      <= end_s_d;
      proc_reset_q <= proc_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      color_q      <= color_d;
      shape_q      <= shape_d;
      max_cnt_q    <= max_cnt_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      mayor_q      <= mayor_d;
      menor_q      <= menor_d;
      igual_q      <= igual_d;
    end
  end

  assign proc_reset = proc_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef CAPTURE_TIMEOUT_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
  logic unused_timeout_c;
  assign unused_timeout_c = timeout_q;
`endif
  assign color      = color_q;
  assign shape      = shape_q;
  assign max_cnt    = max_cnt_q;

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Processor-side controller that sequences one shot of the camera image-processing datapath: holds the datapath in reset, releases it, waits for its end-of-frame flag, then latches the colour counters and row-width trend counters.
- Classifies the latched values into a dominant colour and a shape code and presents them to the SoC register bank with busy/done status.
- Runs in the 100 MHz system domain; the datapath's end flag arrives from the pixel-clock domain and is synchronised here.

Parameters:
- RST_CYCLES, 4, number of clk cycles proc_reset is held high before release.
- TIMEOUT_CYCLES, 10000000, watchdog limit in clk cycles while waiting for proc_end (100 ms at 100 MHz).
- MIN_PIXELS, 64, minimum winning colour count for a valid colour result.
- CW, 24, width of the reset/watchdog cycle counter.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset (reset=0 clears the block).
- start  in  1  one-cycle request from the processor to capture one frame.
- proc_end  in  1  datapath end-of-frame flag, pixel-clock domain, level.
- red_cnt  in  20  datapath red pixel count.
- green_cnt  in  20  datapath green pixel count.
- blue_cnt  in  20  datapath blue pixel count.
- w_mayor  in  12  rows wider than the previous row.
- w_menor  in  12  rows narrower than the previous row.
- w_igual  in  12  rows of equal width to the previous row.
- proc_reset  out  1  active-high reset to the datapath.
- busy  out  1  capture in progress.
- done  out  1  result valid; sticky until next start.
- timeout  out  1  last capture aborted by the watchdog.
- color  out  2  0 none, 1 red, 2 green, 3 blue.
- shape  out  2  0 none, 1 square, 2 triangle, 3 circle.
- max_cnt  out  20  count of the winning colour.

Behaviour:
- Reset (reset=0, async): state IDLE, proc_reset=1, busy=0, done=0, timeout=0, color=0, shape=0, max_cnt=0, counter=0, synchroniser flops=0.
- proc_end passes through a 2-flop synchroniser into end_s. Counts are sampled only after end_s=1 plus the SETTLE state, so they are quasi-static at the sample point.
- IDLE: proc_reset=1. On start=1, clear done and timeout, set busy=1, counter=0, go to RST.
- RST: proc_reset=1. Counter increments each cycle. When counter==RST_CYCLES-1, clear the counter and go to WAIT. proc_reset is high for exactly RST_CYCLES cycles counted from the cycle after start.
- WAIT: proc_reset=0. Counter increments each cycle.
  - end_s=1: go to SETTLE.
  - Watchdog expiry: go to IDLE with timeout=1, done=1, busy=0, color=0, shape=0, max_cnt=0.
  - If end_s rises in the same cycle the watchdog expires, end_s wins.
- SETTLE: 1 cycle, no action. Then LATCH.
- LATCH: register all seven inputs. Go to CLASSIFY.
- CLASSIFY: 1 cycle, combinational over the latched values.
  - Colour: maximum of red/green/blue, ties resolved red>green>blue. max_cnt = winning count. If the winner < MIN_PIXELS, then color=0.
  - Shape: evaluated with 14-bit sums, no overflow, in this order.
    - If w_mayor+w_menor+w_igual==0, shape=0.
    - Else if w_igual > w_mayor+w_menor, shape=1.
    - Else if w_mayor > 2*w_menor, shape=2.
    - Else shape=3.
  - Then DONE.
- DONE: done=1, busy=0, proc_reset=1 (datapath parked). Go to IDLE.
- Latency: start to done = RST_CYCLES + (cycles until end_s) + 3.
- start while busy=1 is ignored.
- start in the same cycle that done is asserted is ignored; start in IDLE is accepted.
- Outputs color/shape/max_cnt hold their values until the next CLASSIFY or timeout.
- Reset mid-capture aborts immediately to the reset values; proc_reset rises asynchronously.

Optional Feature:
- Macro CAPTURE_TIMEOUT_EN.
- Defined: watchdog active as described; timeout reachable.
- Undefined: WAIT only exits on end_s; the counter is not incremented in WAIT; timeout is tied 0; TIMEOUT_CYCLES is unused.

Test Plan:
- Reset: reset=0 then 1 -> proc_reset=1, busy=0, done=0, color=0, shape=0, max_cnt=0.
- Red square: start; proc_end=1 at 50 cycles; red=500, green=40, blue=30, mayor=2, menor=3, igual=40 -> proc_reset high exactly 4 cycles; done=1, color=1, shape=1, max_cnt=500, busy=0.
- Tie/threshold: green=blue=200, red=0, mayor=30, menor=5, igual=10 -> color=2, shape=2. Rerun with green=blue=60 -> color=0, max_cnt=60.
- Empty/circle: all counts 0 -> color=0, shape=0. Then mayor=10, menor=10, igual=5 -> shape=3.
- Busy/start collision: start pulsed during WAIT and in the same cycle as done -> ignored, only one capture observed. A start one cycle later is accepted and done clears.
- Timeout (TIMEOUT_CYCLES=100, macro defined): proc_end held 0 -> done=1, timeout=1 at cycle 4+100. With the macro undefined, the block stays busy until proc_end=1 arrives.
